// File: rtl/dt1_mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
// A request is held stable until the memory returns DMemReady.
interface dt1_mem_stage_if;
  logic        DMemReq;
  logic        DMemWe;
  logic [31:0] DMemAddr;
  logic [3:0]  DMemBe;
  logic [31:0] DMemWData;
  logic [31:0] DMemRData;
  logic        DMemReady;

  modport master (
    output DMemReq, DMemWe, DMemAddr, DMemBe, DMemWData,
    input  DMemRData, DMemReady
  );

  modport slave (
    input  DMemReq, DMemWe, DMemAddr, DMemBe, DMemWData,
    output DMemRData, DMemReady
  );
endinterface

// File: rtl/dt1_mem_stage.sv
// RV32I memory stage plus MEM/WB register. Aligned loads/stores use the ready-handshaked
// data bus and stall the pipeline until the access completes or times out.
module dt1_mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   RegWriteM,
  input  logic [1:0]             ResultSrcM,
  input  logic                   MemWriteM,
  input  logic [2:0]             Funct3M,
  input  logic [4:0]             RdM,
  input  logic [31:0]            ALUResultM,
  input  logic [31:0]            WriteDataM,
  input  logic [31:0]            PCPlus4M,
  dt1_mem_stage_if.master        dmem,
  output logic                   StallM,
  output logic                   RegWriteW,
  output logic [1:0]             ResultSrcW,
  output logic [4:0]             RdW,
  output logic [31:0]            ALUResultW,
  output logic [31:0]            ReadDataW,
  output logic [31:0]            PCPlus4W,
  output logic                   MisalignW,
  output logic                   BusErrW
);

  localparam int unsigned    CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        is_store, is_load, mem_op, misalign, access, timeout_hit;
  logic [1:0]  offs;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        req, stall, done, bus_err;

  logic        w_regwrite, w_misalign, w_buserr;
  logic [1:0]  w_resultsrc;
  logic [4:0]  w_rd;
  logic [31:0] w_alu, w_rdata, w_pc;

  // A store wins when both store and load are flagged.
  assign is_store = MemWriteM;
  assign is_load  = (ResultSrcM == 2'b01) && !MemWriteM;
  assign mem_op   = is_store || is_load;
  assign offs     = ALUResultM[1:0];
  assign misalign = mem_op && (((Funct3M[1:0] == 2'b01) && offs[0]) ||
                               ((Funct3M == 3'b010) && (offs != 2'b00)));
  assign access   = mem_op && !misalign;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntMax);

  always_comb begin
    be    = 4'b1111;
    wdata = WriteDataM;
    if (is_store) begin
      case (Funct3M[1:0])
        2'b00: begin
          be    = 4'b0001 << offs;
          wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          be    = 4'b0011 << offs;
          wdata = {2{WriteDataM[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign ld_byte = dmem.DMemRData[{offs, 3'b000} +: 8];
  assign ld_half = offs[1] ? dmem.DMemRData[31:16] : dmem.DMemRData[15:0];

  always_comb begin
    case (Funct3M)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dmem.DMemRData;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      StIdle: if (access && !dmem.DMemReady) state_d = StWait;
      StWait: begin
        if (dmem.DMemReady || timeout_hit) state_d = StIdle;
        else                               cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req         = 1'b0;
    done        = 1'b0;
    bus_err     = 1'b0;
    w_regwrite  = 1'b0;
    w_resultsrc = 2'b00;
    w_rd        = 5'd0;
    w_alu       = 32'h0;
    w_rdata     = 32'h0;
    w_pc        = 32'h0;
    w_misalign  = 1'b0;
    w_buserr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        req  = access;
        done = !access || dmem.DMemReady;
      end
      StWait: begin
        req     = 1'b1;
        done    = dmem.DMemReady;
        bus_err = !dmem.DMemReady && timeout_hit;
      end
      default: ;
    endcase
    stall = !(done || bus_err);
    // Stalled cycles load a bubble into the W register.
    if (!stall) begin
      w_resultsrc = ResultSrcM;
      w_rd        = RdM;
      w_alu       = ALUResultM;
      w_pc        = PCPlus4M;
      w_misalign  = misalign;
      w_buserr    = bus_err;
      w_regwrite  = RegWriteM && !misalign && !bus_err;
      w_rdata     = (is_load && !misalign && !bus_err) ? ld_data : 32'h0;
    end
  end

  assign dmem.DMemReq   = req && rst_n;
  assign dmem.DMemWe    = req && rst_n && is_store;
  assign dmem.DMemAddr  = {ALUResultM[31:2], 2'b00};
  assign dmem.DMemBe    = be;
  assign dmem.DMemWData = wdata;
  assign StallM         = stall && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= 5'd0;
      ALUResultW <= 32'h0;
      ReadDataW  <= 32'h0;
      PCPlus4W   <= 32'h0;
      MisalignW  <= 1'b0;
      BusErrW    <= 1'b0;
    end else begin
      RegWriteW  <= w_regwrite;
      ResultSrcW <= w_resultsrc;
      RdW        <= w_rd;
      ALUResultW <= w_alu;
      ReadDataW  <= w_rdata;
      PCPlus4W   <= w_pc;
      MisalignW  <= w_misalign;
      BusErrW    <= w_buserr;
    end
  end

endmodule

// File: tb/tb_dt1_mem_stage.sv
// Scoreboard bench for dt1_mem_stage: a driver pushes expected W-register contents per cycle,
// a monitor pops and compares them after every clock edge.
module tb_dt1_mem_stage;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic        StallM, RegWriteW, MisalignW, BusErrW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;

  dt1_mem_stage_if dmem_bus ();

  dt1_mem_stage #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .RdM        (RdM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .PCPlus4M   (PCPlus4M),
    .dmem       (dmem_bus),
    .StallM     (StallM),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .RdW        (RdW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .PCPlus4W   (PCPlus4W),
    .MisalignW  (MisalignW),
    .BusErrW    (BusErrW)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdat;
    logic [31:0] pc;
    logic        mis;
    logic        berr;
  } wrec_t;

  wrec_t q[$];
  int    tests = 0;
  int    fails = 0;
  logic [2:0] lf3 [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h, want %08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * int'(o))) & 32'hFF;
    h = (d >> (16 * int'(o[1]))) & 32'hFFFF;
    case (f3)
      3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  task automatic set_inputs(input logic rw, input logic [1:0] rs, input logic mw,
                            input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                            input logic [31:0] wd, input logic [31:0] pc);
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; Funct3M = f3;
    RdM = rd; ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc;
  endtask

  // One instruction: lat = number of cycles the memory withholds DMemReady.
  task automatic run_instr(input logic rw, input logic [1:0] rs, input logic mw,
                           input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                           input logic [31:0] wd, input logic [31:0] pc, input logic [31:0] rdat,
                           input int lat);
    logic        is_load, is_mem, mis, tout, req_e;
    logic [1:0]  o;
    logic [3:0]  be_e;
    logic [31:0] wd_e;
    int          ncyc;
    wrec_t       fin;
    o       = alu[1:0];
    is_load = (rs == 2'b01) && !mw;
    is_mem  = mw || is_load;
    mis     = is_mem && ((f3[1:0] == 2'b01 && o[0]) || (f3 == 3'b010 && o != 2'b00));
    req_e   = is_mem && !mis;
    tout    = req_e && (lat > int'(TO));
    ncyc    = !req_e ? 1 : (tout ? int'(TO) + 1 : lat + 1);
    be_e    = 4'hF;
    wd_e    = wd;
    if (mw && f3[1:0] == 2'b00) begin
      be_e = 4'(1 << o);
      wd_e = wd[7:0] * 32'h0101_0101;
    end else if (mw && f3[1:0] == 2'b01) begin
      be_e = 4'(3 << o);
      wd_e = wd[15:0] * 32'h0001_0001;
    end
    fin.rw   = rw && !mis && !tout;
    fin.rs   = rs;
    fin.rd   = rd;
    fin.alu  = alu;
    fin.rdat = (is_load && !mis && !tout) ? load_fmt(f3, o, rdat) : 32'h0;
    fin.pc   = pc;
    fin.mis  = mis;
    fin.berr = tout;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #2;
      set_inputs(rw, rs, mw, f3, rd, alu, wd, pc);
      dmem_bus.DMemReady = req_e && (k == lat);
      dmem_bus.DMemRData = (k == lat) ? rdat : $urandom;
      #1;
      chk("dmem_req", 32'(dmem_bus.DMemReq), 32'(req_e));
      chk("stall", 32'(StallM), 32'(k != ncyc - 1));
      if (req_e) begin
        chk("dmem_addr", dmem_bus.DMemAddr, {alu[31:2], 2'b00});
        chk("dmem_we", 32'(dmem_bus.DMemWe), 32'(mw));
        chk("dmem_be", 32'(dmem_bus.DMemBe), 32'(be_e));
        if (mw) chk("dmem_wdata", dmem_bus.DMemWData, wd_e);
      end else begin
        chk("dmem_we_idle", 32'(dmem_bus.DMemWe), 32'h0);
      end
      q.push_back((k == ncyc - 1) ? fin : '0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(dmem_bus.DMemReq), 32'h0);
    chk({tag, "_stall"}, 32'(StallM), 32'h0);
    chk({tag, "_w_ctl"}, 32'({RegWriteW, ResultSrcW, RdW, MisalignW, BusErrW}), 32'h0);
    chk({tag, "_w_alu"}, ALUResultW, 32'h0);
    chk({tag, "_w_rdata"}, ReadDataW, 32'h0);
    chk({tag, "_w_pc"}, PCPlus4W, 32'h0);
  endtask

  // Monitor: the W register updates on every edge, so one record is due per driven cycle.
  initial begin
    wrec_t exp_r, act_r;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        exp_r = q.pop_front();
        act_r = '{RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W, MisalignW,
                  BusErrW};
        tests++;
        if (act_r !== exp_r) begin
          fails++;
          $display("FAIL wb_reg at %0t: got rw=%0d rs=%0d rd=%0d alu=%08h rdat=%08h pc=%08h mis=%0d berr=%0d, want rw=%0d rs=%0d rd=%0d alu=%08h rdat=%08h pc=%08h mis=%0d berr=%0d",
                   $time, act_r.rw, act_r.rs, act_r.rd, act_r.alu, act_r.rdat, act_r.pc,
                   act_r.mis, act_r.berr, exp_r.rw, exp_r.rs, exp_r.rd, exp_r.alu, exp_r.rdat,
                   exp_r.pc, exp_r.mis, exp_r.berr);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int          kind, lat;
    logic        mw;
    logic [1:0]  rs;
    logic [2:0]  f3;
    rst_n = 1'b1;
    set_inputs(1'b0, 2'b00, 1'b0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    dmem_bus.DMemReady = 1'b0;
    dmem_bus.DMemRData = 32'h0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed cases
    run_instr(1'b1, 2'b00, 1'b0, 3'd0, 5'd3, 32'h0000_1234, 32'h0, 32'h0000_0100, 32'h0, 0);
    run_instr(1'b1, 2'b10, 1'b0, 3'd0, 5'd1, 32'h0000_5678, 32'h0, 32'h0000_0104, 32'h0, 0);
    run_instr(1'b1, 2'b01, 1'b0, 3'b000, 5'd5, 32'h0000_1003, 32'h0, 32'h8, 32'h80FF_FF7F, 0);
    run_instr(1'b1, 2'b01, 1'b0, 3'b100, 5'd5, 32'h0000_1003, 32'h0, 32'h8, 32'h80FF_FF7F, 0);
    run_instr(1'b0, 2'b00, 1'b1, 3'b001, 5'd0, 32'h0000_2002, 32'hDEAD_BEEF, 32'hC, 32'h0, 3);
    run_instr(1'b1, 2'b01, 1'b0, 3'b010, 5'd9, 32'h0000_3001, 32'h0, 32'h10, 32'h1111_2222, 0);
    run_instr(1'b1, 2'b01, 1'b0, 3'b010, 5'd9, 32'h0000_3000, 32'h0, 32'h14, 32'hCAFE_F00D, 20);
    run_instr(1'b1, 2'b01, 1'b0, 3'b101, 5'd4, 32'h0000_3002, 32'h0, 32'h18, 32'h9876_5432,
              int'(TO));
    run_instr(1'b1, 2'b00, 1'b0, 3'd0, 5'd2, 32'h0000_0040, 32'h0, 32'h1C, 32'h0, 0);

    // Reset in the middle of a waiting access
    @(posedge clk); #2;
    set_inputs(1'b1, 2'b01, 1'b0, 3'b010, 5'd6, 32'h0000_0040, 32'h0, 32'h20);
    dmem_bus.DMemReady = 1'b0;
    #1 q.push_back('0);
    @(posedge clk); #3;
    chk("stall_wait", 32'(StallM), 32'h1);
    q.push_back('0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    q.delete();
    set_inputs(1'b0, 2'b00, 1'b0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    #1 chk_reset_outputs("reset_wait");
    @(posedge clk); #2;
    rst_n = 1'b1;
    run_instr(1'b1, 2'b00, 1'b0, 3'd0, 5'd7, 32'hDEAD_0000, 32'h0, 32'h0000_0200, 32'h0, 0);

    // Reset right after a non-zero W capture
    @(posedge clk); #2;
    rst_n = 1'b0;
    set_inputs(1'b0, 2'b00, 1'b0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    #1 chk_reset_outputs("reset_async");
    @(posedge clk); #2;
    rst_n = 1'b1;

    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 3);
      mw   = (kind == 3);
      rs   = (kind == 0) ? 2'b00 : (kind == 1) ? 2'b10 : (kind == 2) ? 2'b01
                                                         : 2'($urandom_range(0, 1));
      f3   = mw ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 7)];
      lat  = ($urandom_range(0, 7) == 0) ? $urandom_range(int'(TO), int'(TO) + 3)
                                         : $urandom_range(0, 3);
      run_instr(1'($urandom), rs, mw, f3, 5'($urandom), $urandom, $urandom, $urandom,
                $urandom, lat);
    end

    @(posedge clk); #2;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
